// File: rtl/allocator_rr_if.sv
// Flit-stream bundle between the upstream channels, the round-robin
// allocator and the output FIFO write port.
interface allocator_rr_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 11,
  parameter int SRC_W  = $clog2(NUM_IN)
);
  logic [NUM_IN-1:0]        req;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic                     out_FIFO_full;
  logic [NUM_IN-1:0]        ready;
  logic                     out_FIFO_wr;
  logic [DATA_W-1:0]        data_out;
  logic [SRC_W-1:0]         out_src;

  // Upstream channels plus the output FIFO status side.
  modport master (
    output req, data_in, out_FIFO_full,
    input  ready, out_FIFO_wr, data_out, out_src
  );

  // The allocator itself.
  modport slave (
    input  req, data_in, out_FIFO_full,
    output ready, out_FIFO_wr, data_out, out_src
  );
endinterface

// File: rtl/allocator_rr.sv
// Round-robin wormhole allocator: merges NUM_IN flit streams into one
// output FIFO write port. A grant is taken in IDLE (one bubble cycle) and
// held in LOCKED until the tail flit moves (LOCK_PKT=1) or for a single
// flit (LOCK_PKT=0). Output flit, source tag and write strobe are registered.
module allocator_rr #(
  parameter int NUM_IN   = 4,
  parameter int DATA_W   = 11,
  parameter int LOCK_PKT = 1,
  parameter int SRC_W    = $clog2(NUM_IN)
) (
  input  logic           clk,
  input  logic           reset_n,
  allocator_rr_if.slave  bus
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_LOCKED = 1'b1;
  localparam logic [SRC_W-1:0] LAST_CH   = SRC_W'(NUM_IN - 1);

  logic [0:0]        state_r;
  logic [SRC_W-1:0]  owner_r;
  logic [SRC_W-1:0]  last_grant_r;
  logic              wr_r;
  logic [DATA_W-1:0] data_r;
  logic [SRC_W-1:0]  src_r;

  logic [SRC_W-1:0]  hi_pick_s;
  logic [SRC_W-1:0]  lo_pick_s;
  logic              hi_found_s;
  logic [SRC_W-1:0]  pick_s;
  logic [NUM_IN-1:0] ready_s;
  logic              xfer_s;
  logic [DATA_W-1:0] owner_flit_s;
  logic              release_s;

  // Round-robin pick: lowest requester above last_grant, else lowest overall (wrap).
  always_comb begin
    hi_pick_s  = '0;
    lo_pick_s  = '0;
    hi_found_s = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (bus.req[i] && (i > int'(last_grant_r))) begin
        hi_pick_s  = SRC_W'(i);
        hi_found_s = 1'b1;
      end else begin
        hi_found_s = hi_found_s;
      end
      if (bus.req[i]) begin
        lo_pick_s = SRC_W'(i);
      end else begin
        lo_pick_s = lo_pick_s;
      end
    end
    if (hi_found_s) begin
      pick_s = hi_pick_s;
    end else begin
      pick_s = lo_pick_s;
    end
  end

  // Only the owner may move a flit, and only while the output FIFO has room.
  always_comb begin
    ready_s = '0;
    if ((state_r == ST_LOCKED) && !bus.out_FIFO_full) begin
      ready_s[owner_r] = bus.req[owner_r];
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s       = |ready_s;
  assign owner_flit_s = bus.data_in[int'(owner_r)*DATA_W +: DATA_W];
  assign release_s    = xfer_s && ((LOCK_PKT == 0) || owner_flit_s[DATA_W-1]);

  // Grant state: arbitrate in IDLE, hold the owner in LOCKED until release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= '0;
      last_grant_r <= LAST_CH;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            owner_r <= pick_s;
            state_r <= ST_LOCKED;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (release_s) begin
            last_grant_r <= owner_r;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: capture the owner's flit and tag on every transfer edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_r   <= 1'b0;
      data_r <= '0;
      src_r  <= '0;
    end else if (xfer_s) begin
      wr_r   <= 1'b1;
      data_r <= owner_flit_s;
      src_r  <= owner_r;
    end else begin
      wr_r   <= 1'b0;
    end
  end

  assign bus.ready       = ready_s;
  assign bus.out_FIFO_wr = wr_r;
  assign bus.data_out    = data_r;
  assign bus.out_src     = src_r;

endmodule

// File: tb/tb_allocator_rr.sv
// Bench for allocator_rr: a packet-mode instance (a) and a per-flit instance (b)
// checked every cycle against a grant/priority model, plus directed sequence checks.
module tb_allocator_rr;
  localparam int N  = 4;
  localparam int W  = 11;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  allocator_rr_if #(.NUM_IN(N), .DATA_W(W), .SRC_W(SW)) ifa ();
  allocator_rr_if #(.NUM_IN(N), .DATA_W(W), .SRC_W(SW)) ifb ();

  allocator_rr #(.NUM_IN(N), .DATA_W(W), .LOCK_PKT(1), .SRC_W(SW)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  allocator_rr #(.NUM_IN(N), .DATA_W(W), .LOCK_PKT(0), .SRC_W(SW)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  logic [N-1:0]   req_v  [2];
  logic [N*W-1:0] din_v  [2];
  logic           full_v [2];
  logic [N-1:0]   hold_v [2];
  logic [N-1:0]   rdy    [2];
  logic           wr     [2];
  logic [W-1:0]   dout   [2];
  logic [SW-1:0]  src    [2];

  assign ifa.req = req_v[0];  assign ifa.data_in = din_v[0];  assign ifa.out_FIFO_full = full_v[0];
  assign ifb.req = req_v[1];  assign ifb.data_in = din_v[1];  assign ifb.out_FIFO_full = full_v[1];
  assign rdy[0] = ifa.ready;  assign wr[0] = ifa.out_FIFO_wr;  assign dout[0] = ifa.data_out;  assign src[0] = ifa.out_src;
  assign rdy[1] = ifb.ready;  assign wr[1] = ifb.out_FIFO_wr;  assign dout[1] = ifb.data_out;  assign src[1] = ifb.out_src;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [W-1:0] fq [2][N][$];   // per-channel flits still to be offered
  int log_d [2][$];             // observed writes: data, source, cycle
  int log_s [2][$];
  int log_c [2][$];

  // model state: current holder (-1 = none), next channel in line, expected registers
  int           m_owner [2];
  int           m_prio  [2];
  int           m_lock  [2];
  logic         e_wr    [2];
  logic [W-1:0] e_data  [2];
  logic [SW-1:0] e_src  [2];

  task automatic chk(string nm, int inst, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, inst, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        if (fq[k][i].size() > 0 && !hold_v[k][i]) begin
          req_v[k][i] = 1'b1;
          din_v[k][i*W +: W] = fq[k][i][0];
        end else begin
          req_v[k][i] = 1'b0;
          din_v[k][i*W +: W] = '0;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] fire [2];
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) fire[k] = req_v[k] & rdy[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        if (fire[k][i] && fq[k][i].size() > 0) void'(fq[k][i].pop_front());
    drive_inputs();
    #1;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        if (fq[k][i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_drain(int max);
    int n = 0;
    while (pending() && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 0, int'(pending()), 0);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      log_d[k].delete(); log_s[k].delete(); log_c[k].delete();
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hold_v[k] = '0;
      full_v[k] = 1'b0;
      for (int i = 0; i < N; i++) fq[k][i].delete();
    end
    drive_inputs();
    repeat (3) step();
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic check_log(int k, string nm, input int ed[$], input int es[$]);
    chk({nm, "_count"}, k, log_d[k].size(), ed.size());
    if (log_d[k].size() == ed.size()) begin
      for (int j = 0; j < ed.size(); j++) begin
        chk({nm, "_data"}, k, log_d[k][j], ed[j]);
        chk({nm, "_src"}, k, log_s[k][j], es[j]);
      end
    end
  endtask

  // Per-cycle compare against the model, then advance the model over the coming edge.
  initial begin
    logic [N-1:0] exp_rdy;
    logic [W-1:0] flit;
    int c;
    m_lock[0] = 1;
    m_lock[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) begin
          m_owner[k] = -1; m_prio[k] = 0;
          e_wr[k] = 1'b0; e_data[k] = '0; e_src[k] = '0;
          chk("rst_ready", k, int'(rdy[k]), 0);
          chk("rst_wr", k, int'(wr[k]), 0);
          chk("rst_data", k, int'(dout[k]), 0);
          chk("rst_src", k, int'(src[k]), 0);
        end else begin
          chk("wr", k, int'(wr[k]), int'(e_wr[k]));
          chk("data_out", k, int'(dout[k]), int'(e_data[k]));
          chk("out_src", k, int'(src[k]), int'(e_src[k]));
          if (wr[k]) begin
            log_d[k].push_back(int'(dout[k]));
            log_s[k].push_back(int'(src[k]));
            log_c[k].push_back(cyc);
          end
          exp_rdy = '0;
          if (m_owner[k] >= 0 && req_v[k][m_owner[k]] && !full_v[k]) exp_rdy[m_owner[k]] = 1'b1;
          chk("ready", k, int'(rdy[k]), int'(exp_rdy));
          if (m_owner[k] < 0) begin
            e_wr[k] = 1'b0;
            for (int j = 0; j < N; j++) begin
              c = (m_prio[k] + j) % N;
              if (m_owner[k] < 0 && req_v[k][c]) m_owner[k] = c;
            end
          end else if (exp_rdy != '0) begin
            flit = din_v[k][m_owner[k]*W +: W];
            e_wr[k] = 1'b1;
            e_data[k] = flit;
            e_src[k] = SW'(m_owner[k]);
            if (m_lock[k] == 0 || flit[W-1]) begin
              m_prio[k] = (m_owner[k] + 1) % N;
              m_owner[k] = -1;
            end
          end else begin
            e_wr[k] = 1'b0;
          end
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    int ed[$];
    int es[$];
    for (int k = 0; k < 2; k++) begin
      hold_v[k] = '0; full_v[k] = 1'b0;
    end
    drive_inputs();

    // reset and first grant
    reset_dut();
    chk("t1_rst_ready", 0, int'(rdy[0]), 0);
    chk("t1_rst_wr", 0, int'(wr[0]), 0);
    chk("t1_rst_src", 0, int'(src[0]), 0);
    fq[0][0].push_back(11'h001); fq[0][0].push_back(11'h002); fq[0][0].push_back(11'h403);
    drive_inputs(); #1;
    chk("t1_ready_bubble", 0, int'(rdy[0]), 0);
    step();
    chk("t1_ready_grant", 0, int'(rdy[0]), 1);
    run_drain(20);
    ed = '{'h001, 'h002, 'h403}; es = '{0, 0, 0};
    check_log(0, "t1", ed, es);
    chk("t1_idle_ready", 0, int'(rdy[0]), 0);

    // round robin across all four channels
    reset_dut();
    for (int i = 0; i < N; i++) begin
      fq[0][i].push_back(11'((i << 4) | 1));
      fq[0][i].push_back(11'('h400 | (i << 4) | 2));
    end
    fq[0][0].push_back(11'h005); fq[0][0].push_back(11'h406);
    drive_inputs();
    run_drain(60);
    ed = '{'h001, 'h402, 'h011, 'h412, 'h021, 'h422, 'h031, 'h432, 'h005, 'h406};
    es = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    check_log(0, "t2", ed, es);

    // backpressure mid-packet
    reset_dut();
    fq[0][0].push_back(11'h011); fq[0][0].push_back(11'h012);
    fq[0][0].push_back(11'h013); fq[0][0].push_back(11'h414);
    drive_inputs();
    repeat (3) step();
    full_v[0] = 1'b1;
    repeat (5) begin
      step();
      chk("t3_ready_full", 0, int'(rdy[0]), 0);
      chk("t3_wr_full", 0, int'(wr[0]), 0);
    end
    full_v[0] = 1'b0;
    run_drain(20);
    ed = '{'h011, 'h012, 'h013, 'h414}; es = '{0, 0, 0, 0};
    check_log(0, "t3", ed, es);

    // owner drops req mid-packet while another channel waits
    reset_dut();
    fq[0][2].push_back(11'h021); fq[0][2].push_back(11'h022);
    fq[0][2].push_back(11'h023); fq[0][2].push_back(11'h424);
    drive_inputs();
    repeat (2) step();
    fq[0][1].push_back(11'h431);
    hold_v[0] = 4'b0100;
    drive_inputs();
    repeat (3) begin
      step();
      chk("t4_ready1_held", 0, int'(rdy[0][1]), 0);
      chk("t4_wr_held", 0, int'(wr[0]), 0);
    end
    hold_v[0] = '0;
    drive_inputs();
    run_drain(30);
    ed = '{'h021, 'h022, 'h023, 'h424, 'h431}; es = '{2, 2, 2, 2, 1};
    check_log(0, "t4", ed, es);

    // per-flit mode on instance b
    reset_dut();
    fq[1][0].push_back(11'h001); fq[1][0].push_back(11'h002); fq[1][0].push_back(11'h003);
    fq[1][1].push_back(11'h011); fq[1][1].push_back(11'h012); fq[1][1].push_back(11'h013);
    drive_inputs();
    run_drain(40);
    ed = '{'h001, 'h011, 'h002, 'h012, 'h003, 'h013}; es = '{0, 1, 0, 1, 0, 1};
    check_log(1, "t5", ed, es);
    for (int j = 1; j < log_c[1].size(); j++) chk("t5_gap", 1, log_c[1][j] - log_c[1][j-1], 2);

    // reset mid-packet
    reset_dut();
    fq[0][0].push_back(11'h051); fq[0][0].push_back(11'h052);
    fq[0][0].push_back(11'h053); fq[0][0].push_back(11'h454);
    fq[0][1].push_back(11'h471);
    drive_inputs();
    repeat (3) step();
    chk("t6_wr_before", 0, int'(wr[0]), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_wr_async", 0, int'(wr[0]), 0);
    chk("t6_data_async", 0, int'(dout[0]), 0);
    for (int i = 0; i < N; i++) fq[0][i].delete();
    drive_inputs();
    repeat (2) step();
    reset_n = 1'b1;
    clear_logs();
    fq[0][0].push_back(11'h061); fq[0][0].push_back(11'h462);
    fq[0][1].push_back(11'h471);
    drive_inputs();
    run_drain(30);
    ed = '{'h061, 'h462, 'h471}; es = '{0, 0, 1};
    check_log(0, "t6", ed, es);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/allocator_rr.md
Name: allocator_rr

Overview:
- Parametrised N-input wormhole allocator for the router. It merges NUM_IN flit streams into one output FIFO write port.
- Arbitration is round-robin. In packet mode a grant is held from head flit to tail flit.
- Output data and source index are registered. The output FIFO's full flag provides backpressure.
- Successor to the fixed two-input allocator: adds channel count, data width, per-flit mode and a source tag.

Parameters:
- NUM_IN, 4, number of input channels (2..16).
- DATA_W, 11, flit width; bit DATA_W-1 is the tail marker.
- LOCK_PKT, 1, 1 = hold grant until tail flit transfers; 0 = re-arbitrate after every flit.
- SRC_W, $clog2(NUM_IN), width of the source tag.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_IN  per-channel flit-valid.
- data_in  in  NUM_IN*DATA_W  flattened flits; channel i occupies bits [i*DATA_W +: DATA_W].
- out_FIFO_full  in  1  output FIFO full; must assert with at least 1 entry of slack.
- ready  out  NUM_IN  combinational; a flit moves on channel i at a rising edge when req[i] && ready[i].
- out_FIFO_wr  out  1  registered write strobe.
- data_out  out  DATA_W  registered flit.
- out_src  out  SRC_W  registered index of the channel that supplied data_out.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, owner=0, last_grant=NUM_IN-1, so channel 0 has first priority.
  - out_FIFO_wr=0, data_out=0, out_src=0, ready=0.
- States: IDLE, LOCKED.
- IDLE:
  - ready=0 and no transfer takes place.
  - If any req bit is set, owner is the first requesting channel scanning from (last_grant+1) mod NUM_IN upward with wrap. State goes to LOCKED next cycle.
  - This gives a 1-cycle arbitration bubble per grant.
- LOCKED:
  - ready[owner] = req[owner] && !out_FIFO_full; all other ready bits are 0.
  - On a transfer edge: data_out <= owner's flit, out_src <= owner, out_FIFO_wr <= 1. Otherwise out_FIFO_wr <= 0.
  - Latency is 1 cycle from transfer edge to out_FIFO_wr high. Back-to-back transfers sustain 1 flit/cycle.
- Releasing the grant:
  - LOCK_PKT=1: when the transferred flit has bit DATA_W-1 = 1, set last_grant <= owner and go to IDLE.
  - LOCK_PKT=0: every transfer sets last_grant <= owner and goes to IDLE, regardless of tail.
- Owner drops req mid-packet (LOCK_PKT=1): stay LOCKED, no transfer, out_FIFO_wr=0. Other channels are not served (wormhole hold).
- out_FIFO_full high: no transfer and the state holds. Resuming after it deasserts costs no extra cycle.
- Single-flit packet (head is also tail): one transfer, then IDLE.
- Only one requester: after its packet it is re-granted after the 1-cycle bubble. Priority only rotates among active requesters.
- Reset asserted mid-packet:
  - All outputs clear immediately and the partial packet is abandoned.
  - Upstream is responsible for resynchronising to a packet boundary.
- data_in of non-owner channels is ignored. data_in is sampled only on transfer edges.

Test Plan:
- Reset and first grant: reset_n low 3 cycles, then req=4'b0001 with a 3-flit packet (tail on 3rd) -> ready[0] rises 1 cycle after req. out_FIFO_wr pulses on 3 consecutive cycles with out_src=0 and data_out matching flits 1..3. Back to IDLE.
- Round-robin: req=4'b1111, each channel sends 2-flit packets -> grant order 0,1,2,3,0. One idle cycle between packets. No interleaving of flits from different channels.
- Backpressure: out_FIFO_full high for 5 cycles mid-packet -> ready=0 and out_FIFO_wr=0 during that window. After release the remaining flits arrive in order with no loss or duplication.
- Owner bubble: req[2] drops for 3 cycles mid-packet while req[1]=1 -> ready[1] stays 0. Channel 2 finishes its packet before channel 1 is granted.
- Per-flit mode (LOCK_PKT=0): req=4'b0011, no tail bits set -> out_src alternates 0,1,0,1 every 2 cycles.
- Reset mid-packet: assert reset_n after flit 2 of 4 -> out_FIFO_wr=0 immediately. After release the next grant goes to channel 0 if it is requesting.
